// File: rtl/jtag_pkg.sv
// Shared DMI encodings and dtmcs layout for the JTAG debug transport.
package jtag_pkg;

  localparam logic [1:0] DMI_OP_NOP   = 2'd0;
  localparam logic [1:0] DMI_OP_READ  = 2'd1;
  localparam logic [1:0] DMI_OP_WRITE = 2'd2;

  localparam logic [1:0] DMI_RESP_OK     = 2'd0;
  localparam logic [1:0] DMI_RESP_FAILED = 2'd2;
  localparam logic [1:0] DMI_RESP_BUSY   = 2'd3;

  localparam logic [1:0] DMISTAT_OK   = 2'b00;
  localparam logic [1:0] DMISTAT_ERR  = 2'b10;
  localparam logic [1:0] DMISTAT_BUSY = 2'b11;

  localparam logic [3:0] DTM_VERSION = 4'h1;

  typedef struct packed {
    logic [13:0] zero;
    logic        hardreset;
    logic        dmireset;
    logic        rsvd;
    logic [2:0]  idle;
    logic [1:0]  dmistat;
    logic [5:0]  abits;
    logic [3:0]  version;
  } dtmcs_t;

  function automatic dtmcs_t pack_dtmcs(input logic [2:0] idle,
                                        input logic [1:0] dmistat,
                                        input logic [5:0] abits);
    dtmcs_t d;
    d           = '0;
    d.idle      = idle;
    d.dmistat   = dmistat;
    d.abits     = abits;
    d.version   = DTM_VERSION;
    return d;
  endfunction

endpackage

// File: rtl/jtag_dtm_req_fifo.sv
// In-order request buffer; pointers carry one wrap bit so DEPTH=1 needs no special casing.
module jtag_dtm_req_fifo #(
  parameter int unsigned WIDTH = 41,
  parameter int unsigned DEPTH = 4
) (
  input  logic             i_tck,
  input  logic             i_trst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PTR_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [IDX_W-1:0] w_wr_idx;
  logic [IDX_W-1:0] w_rd_idx;
  logic             w_push;
  logic             w_pop;

  assign w_wr_idx = (DEPTH > 1) ? IDX_W'(r_wr_ptr) : '0;
  assign w_rd_idx = (DEPTH > 1) ? IDX_W'(r_rd_ptr) : '0;
  assign o_empty  = (r_wr_ptr == r_rd_ptr);
  assign o_full   = ((r_wr_ptr - r_rd_ptr) == PTR_W'(DEPTH));
  assign o_head   = r_mem[w_rd_idx];
  assign w_push   = i_push & ~o_full;
  assign w_pop    = i_pop & ~o_empty;

  always_ff @(posedge i_tck or negedge i_trst_n) begin
    if (!i_trst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
    end
  end

  // Storage is pure datapath; validity is tracked by the pointers alone.
  always_ff @(posedge i_tck) begin
    if (w_push && !i_flush) r_mem[w_wr_idx] <= i_data;
  end

endmodule

// File: rtl/jtag_dtm_q.sv
// Queued DTM: buffers DMI requests from the TAP, issues them in order and tracks sticky status.
module jtag_dtm_q
  import jtag_pkg::*;
#(
  parameter int unsigned DMI_ADDR_BITS = 7,
  parameter int unsigned DMI_DATA_BITS = 32,
  parameter int unsigned DMI_OP_BITS   = 2,
  parameter int unsigned REQ_DEPTH     = 4,
  parameter logic [2:0]  IDLE_CYCLES   = 3'd1,
  parameter logic [31:0] IDCODE        = 32'h1E200A6F,
  localparam int unsigned DMI_BITS     = DMI_ADDR_BITS + DMI_DATA_BITS + DMI_OP_BITS
) (
  input  logic                jtag_tck_i,
  input  logic                jtag_trst_ni,
  input  logic                tap_req_i,
  input  logic [DMI_BITS-1:0] tap_data_i,
  input  logic                dmireset_i,
  input  logic                dmihardreset_i,
  output logic [DMI_BITS-1:0] dtm_data_o,
  output logic                dtm_valid_o,
  input  logic                dmi_ready_i,
  input  logic [DMI_BITS-1:0] dmi_data_i,
  input  logic                dmi_valid_i,
  output logic                dtm_ready_o,
  output logic [DMI_BITS-1:0] data_o,
  output logic [31:0]         idcode_o,
  output logic [31:0]         dtmcs_o
);

  localparam int unsigned RESP_BITS = DMI_BITS - DMI_OP_BITS;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]           r_state;
  logic [1:0]           w_state_next;
  logic                 r_valid;
  logic                 w_valid_next;
  logic [DMI_BITS-1:0]  r_req_data;
  logic [DMI_BITS-1:0]  w_req_data_next;
  logic                 r_sticky_busy;
  logic                 r_sticky_err;
  logic [RESP_BITS-1:0] r_resp_q;
  logic [DMI_BITS-1:0]  r_data_o;
  logic [DMI_BITS-1:0]  w_data_next;
  dtmcs_t               r_dtmcs;
  logic [1:0]           w_dmistat;

  logic                 w_full;
  logic                 w_empty;
  logic [DMI_BITS-1:0]  w_head;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_overflow;
  logic                 w_resp_take;
  logic                 w_req_rw;
  logic                 w_req_live;
  logic                 w_busy;
  logic [DMI_OP_BITS-1:0] w_req_op;
  logic [DMI_OP_BITS-1:0] w_resp_op;

  assign w_req_op   = tap_data_i[DMI_OP_BITS-1:0];
  assign w_resp_op  = dmi_data_i[DMI_OP_BITS-1:0];
  assign w_req_rw   = (w_req_op == DMI_OP_BITS'(DMI_OP_READ)) ||
                      (w_req_op == DMI_OP_BITS'(DMI_OP_WRITE));
  // Hardreset and dmireset both swallow a same-cycle request; stickies block new work.
  assign w_req_live = tap_req_i & w_req_rw & ~dmihardreset_i & ~dmireset_i &
                      ~r_sticky_busy & ~r_sticky_err;
  assign w_push     = w_req_live & ~w_full;
  assign w_overflow = w_req_live & w_full;
  assign w_busy     = ~w_empty | (r_state != S_IDLE);

  jtag_dtm_req_fifo #(
    .WIDTH (DMI_BITS),
    .DEPTH (REQ_DEPTH)
  ) u_req_fifo (
    .i_tck    (jtag_tck_i),
    .i_trst_n (jtag_trst_ni),
    .i_flush  (dmihardreset_i),
    .i_push   (w_push),
    .i_pop    (w_pop),
    .i_data   (tap_data_i),
    .o_full   (w_full),
    .o_empty  (w_empty),
    .o_head   (w_head)
  );

  always_ff @(posedge jtag_tck_i or negedge jtag_trst_ni) begin
    if (!jtag_trst_ni) begin
      r_state    <= S_IDLE;
      r_valid    <= 1'b0;
      r_req_data <= '0;
    end else begin
      r_state    <= w_state_next;
      r_valid    <= w_valid_next;
      r_req_data <= w_req_data_next;
    end
  end

  // Valid rises one cycle after entering S_REQ; the handshake only counts once it is visible.
  always_comb begin
    w_state_next    = r_state;
    w_valid_next    = r_valid;
    w_req_data_next = r_req_data;
    w_pop           = 1'b0;
    w_resp_take     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) w_state_next = S_REQ;
      end
      S_REQ: begin
        if (r_valid && dmi_ready_i) begin
          w_pop        = 1'b1;
          w_valid_next = 1'b0;
          w_state_next = S_WAIT;
        end else if (!r_valid) begin
          w_valid_next    = 1'b1;
          w_req_data_next = w_head;
        end
      end
      S_WAIT: begin
        if (dmi_valid_i) begin
          w_resp_take  = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
    if (dmihardreset_i) begin
      w_state_next = S_IDLE;
      w_valid_next = 1'b0;
      w_pop        = 1'b0;
      w_resp_take  = 1'b0;
    end
  end

  always_ff @(posedge jtag_tck_i or negedge jtag_trst_ni) begin
    if (!jtag_trst_ni) begin
      r_sticky_busy <= 1'b0;
      r_sticky_err  <= 1'b0;
      r_resp_q      <= '0;
    end else if (dmihardreset_i) begin
      r_sticky_busy <= 1'b0;
      r_sticky_err  <= 1'b0;
      r_resp_q      <= '0;
    end else begin
      if (dmireset_i) begin
        r_sticky_busy <= 1'b0;
        r_sticky_err  <= 1'b0;
      end else if (w_overflow) begin
        r_sticky_busy <= 1'b1;
      end
      if (w_resp_take) begin
        r_resp_q <= dmi_data_i[DMI_BITS-1:DMI_OP_BITS];
        if (w_resp_op != '0) r_sticky_err <= 1'b1;
      end
    end
  end

  always_comb begin
    w_dmistat = DMISTAT_OK;
    if (r_sticky_busy)     w_dmistat = DMISTAT_BUSY;
    else if (r_sticky_err) w_dmistat = DMISTAT_ERR;
  end

  // Busy (sticky or transient) hides the last response from the debugger.
  always_comb begin
    w_data_next = {r_resp_q, DMI_OP_BITS'(DMISTAT_OK)};
    if (r_sticky_busy || w_busy) w_data_next = DMI_BITS'(DMISTAT_BUSY);
    else if (r_sticky_err)       w_data_next = {r_resp_q, DMI_OP_BITS'(DMISTAT_ERR)};
  end

  always_ff @(posedge jtag_tck_i or negedge jtag_trst_ni) begin
    if (!jtag_trst_ni) begin
      r_data_o <= '0;
      r_dtmcs  <= pack_dtmcs(IDLE_CYCLES, DMISTAT_OK, 6'(DMI_ADDR_BITS));
    end else begin
      r_data_o <= w_data_next;
      r_dtmcs  <= pack_dtmcs(IDLE_CYCLES, w_dmistat, 6'(DMI_ADDR_BITS));
    end
  end

  assign dtm_valid_o = r_valid;
  assign dtm_data_o  = r_req_data;
  assign dtm_ready_o = 1'b1;
  assign data_o      = r_data_o;
  assign dtmcs_o     = r_dtmcs;
  assign idcode_o    = IDCODE;

endmodule

// File: tb/tb_jtag_dtm_q.sv
// Self-checking bench for jtag_dtm_q: request table plus hand-written corner sequences.
module tb_jtag_dtm_q;

  localparam int unsigned DB = 41;

  logic          clk = 1'b0;
  logic          trst_n;
  logic          tap_req_i;
  logic [DB-1:0] tap_data_i;
  logic          dmireset_i;
  logic          dmihardreset_i;
  logic [DB-1:0] dtm_data_o;
  logic          dtm_valid_o;
  logic          dmi_ready_i;
  logic [DB-1:0] dmi_data_i;
  logic          dmi_valid_i;
  logic          dtm_ready_o;
  logic [DB-1:0] data_o;
  logic [31:0]   idcode_o;
  logic [31:0]   dtmcs_o;

  jtag_dtm_q dut (
    .jtag_tck_i     (clk),
    .jtag_trst_ni   (trst_n),
    .tap_req_i      (tap_req_i),
    .tap_data_i     (tap_data_i),
    .dmireset_i     (dmireset_i),
    .dmihardreset_i (dmihardreset_i),
    .dtm_data_o     (dtm_data_o),
    .dtm_valid_o    (dtm_valid_o),
    .dmi_ready_i    (dmi_ready_i),
    .dmi_data_i     (dmi_data_i),
    .dmi_valid_i    (dmi_valid_i),
    .dtm_ready_o    (dtm_ready_o),
    .data_o         (data_o),
    .idcode_o       (idcode_o),
    .dtmcs_o        (dtmcs_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [DB-1:0] exp_q[$];
  logic [DB-1:0] obs_q[$];

  // Log every completed request handshake.
  always @(posedge clk) begin
    if (trst_n && dtm_valid_o && dmi_ready_i) obs_q.push_back(dtm_data_o);
  end

  typedef struct {
    logic [6:0]    addr;
    logic [31:0]   data;
    logic [1:0]    op;
    logic [1:0]    resp_op;
    logic [31:0]   resp_data;
    logic [1:0]    exp_stat;
    logic [DB-1:0] exp_data_o;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic push_req(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op,
                          input bit expect_issue);
    tap_data_i = {a, d, op};
    tap_req_i  = 1'b1;
    tick();
    tap_req_i  = 1'b0;
    if (expect_issue) exp_q.push_back({a, d, op});
  endtask

  task automatic pulse_dmireset();
    dmireset_i = 1'b1;
    tick();
    dmireset_i = 1'b0;
  endtask

  // Accept one request, then return the given response.
  task automatic serve(input logic [DB-1:0] resp);
    int n;
    n = 0;
    dmi_ready_i = 1'b1;
    while (!dtm_valid_o && n < 30) begin
      tick();
      n++;
    end
    check("serve_valid", 64'(dtm_valid_o), 64'd1);
    tick();
    dmi_ready_i = 1'b0;
    dmi_valid_i = 1'b1;
    dmi_data_i  = resp;
    tick();
    dmi_valid_i = 1'b0;
  endtask

  task automatic sb_drain(input string name);
    logic [DB-1:0] got;
    while (obs_q.size() > 0) begin
      got = obs_q.pop_front();
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL %s: unexpected request %0h, none expected", name, got);
      end else begin
        check(name, 64'(got), 64'(exp_q.pop_front()));
      end
    end
  endtask

  initial begin
    vecs[0] = '{7'h01, 32'h00000001, 2'd2, 2'd0, 32'hA5A5A5A5, 2'b00, {7'h01, 32'hA5A5A5A5, 2'b00}};
    vecs[1] = '{7'h11, 32'h00000000, 2'd1, 2'd2, 32'h12345678, 2'b10, {7'h11, 32'h12345678, 2'b10}};
    vecs[2] = '{7'h05, 32'h00000000, 2'd1, 2'd3, 32'hCAFEF00D, 2'b10, {7'h05, 32'hCAFEF00D, 2'b10}};
    vecs[3] = '{7'h22, 32'h11111111, 2'd0, 2'd0, 32'h0,        2'b00, {7'h05, 32'hCAFEF00D, 2'b00}};
    vecs[4] = '{7'h22, 32'h22222222, 2'd3, 2'd0, 32'h0,        2'b00, {7'h05, 32'hCAFEF00D, 2'b00}};
    vecs[5] = '{7'h7F, 32'hFFFFFFFF, 2'd2, 2'd0, 32'h00000000, 2'b00, {7'h7F, 32'h00000000, 2'b00}};

    trst_n = 1'b0; tap_req_i = 1'b0; tap_data_i = '0; dmireset_i = 1'b0;
    dmihardreset_i = 1'b0; dmi_ready_i = 1'b0; dmi_data_i = '0; dmi_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_idcode", 64'(idcode_o), 64'h1E200A6F);
    check("rst_dtmcs", 64'(dtmcs_o), 64'h00001071);
    check("rst_data_o", 64'(data_o), 64'd0);
    check("rst_valid", 64'(dtm_valid_o), 64'd0);
    check("rst_ready", 64'(dtm_ready_o), 64'd1);
    @(negedge clk);
    trst_n = 1'b1;
    tick();

    // Issue latency and held request.
    push_req(7'h10, 32'hDEADBEEF, 2'd2, 1'b1);
    check("lat_edge_n", 64'(dtm_valid_o), 64'd0);
    tick();
    check("lat_edge_n1", 64'(dtm_valid_o), 64'd0);
    tick();
    check("lat_edge_n2", 64'(dtm_valid_o), 64'd1);
    check("lat_data", 64'(dtm_data_o), 64'({7'h10, 32'hDEADBEEF, 2'b10}));
    serve({7'h10, 32'hDEADBEEF, 2'b00});
    repeat (3) tick();
    check("wr_data_o", 64'(data_o), 64'({7'h10, 32'hDEADBEEF, 2'b00}));
    check("wr_dmistat", 64'(dtmcs_o[11:10]), 64'd0);
    sb_drain("lat_req");

    for (int i = 0; i < 6; i++) begin
      pulse_dmireset();
      tick();
      push_req(vecs[i].addr, vecs[i].data, vecs[i].op, (vecs[i].op == 2'd1) || (vecs[i].op == 2'd2));
      if ((vecs[i].op == 2'd1) || (vecs[i].op == 2'd2))
        serve({vecs[i].addr, vecs[i].resp_data, vecs[i].resp_op});
      repeat (4) tick();
      check($sformatf("vec%0d_data_o", i), 64'(data_o), 64'(vecs[i].exp_data_o));
      check($sformatf("vec%0d_dmistat", i), 64'(dtmcs_o[11:10]), 64'(vecs[i].exp_stat));
      sb_drain($sformatf("vec%0d_req", i));
    end

    // Fill the queue, overflow, recover, drain in order.
    pulse_dmireset();
    dmi_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_req(7'(8'h20 + i), 32'h1000 + 32'(i), 2'd2, 1'b1);
      tick();
    end
    push_req(7'h24, 32'h1004, 2'd2, 1'b0);
    repeat (3) tick();
    check("ovf_dmistat", 64'(dtmcs_o[11:10]), 64'd3);
    check("ovf_data_o", 64'(data_o), 64'd3);
    pulse_dmireset();
    repeat (3) tick();
    check("ovf_clr_dmistat", 64'(dtmcs_o[11:10]), 64'd0);
    check("ovf_busy_data_o", 64'(data_o), 64'd3);
    for (int i = 0; i < 4; i++) serve({7'(8'h20 + i), 32'hB000 + 32'(i), 2'b00});
    repeat (3) tick();
    check("ovf_final_data_o", 64'(data_o), 64'({7'h23, 32'hB003, 2'b00}));
    sb_drain("ovf_order");

    // Error response makes later requests drop until dmireset.
    pulse_dmireset();
    push_req(7'h11, 32'h0, 2'd1, 1'b1);
    serve({7'h11, 32'h12345678, 2'b10});
    repeat (3) tick();
    check("err_dmistat", 64'(dtmcs_o[11:10]), 64'd2);
    check("err_data_o", 64'(data_o), 64'({7'h11, 32'h12345678, 2'b10}));
    push_req(7'h30, 32'h30, 2'd2, 1'b0);
    dmi_ready_i = 1'b1;
    repeat (10) tick();
    check("err_drop_valid", 64'(dtm_valid_o), 64'd0);
    dmi_ready_i = 1'b0;
    tap_data_i = {7'h32, 32'h32, 2'd2};
    tap_req_i  = 1'b1;
    dmireset_i = 1'b1;
    tick();
    tap_req_i  = 1'b0;
    dmireset_i = 1'b0;
    dmi_ready_i = 1'b1;
    repeat (6) tick();
    check("rst_vs_req_valid", 64'(dtm_valid_o), 64'd0);
    dmi_ready_i = 1'b0;
    push_req(7'h31, 32'h31, 2'd2, 1'b1);
    serve({7'h31, 32'h31, 2'b00});
    repeat (3) tick();
    check("err_recover_dmistat", 64'(dtmcs_o[11:10]), 64'd0);
    sb_drain("err_req");

    // Hardreset while waiting for a response with two still queued.
    dmi_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) push_req(7'(8'h40 + i), 32'h4000 + 32'(i), 2'd2, 1'b1);
    serve_accept_only();
    dmihardreset_i = 1'b1;
    tick();
    dmihardreset_i = 1'b0;
    check("hr_valid", 64'(dtm_valid_o), 64'd0);
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    dmi_valid_i = 1'b1;
    dmi_data_i  = {7'h40, 32'hBAD, 2'b10};
    tick();
    dmi_valid_i = 1'b0;
    dmi_ready_i = 1'b1;
    repeat (10) tick();
    check("hr_idle_valid", 64'(dtm_valid_o), 64'd0);
    check("hr_data_o", 64'(data_o), 64'd0);
    check("hr_dtmcs", 64'(dtmcs_o), 64'h00001071);
    dmi_ready_i = 1'b0;
    sb_drain("hr_req");

    // Asynchronous reset while a request is on the link.
    push_req(7'h50, 32'h5050, 2'd2, 1'b0);
    repeat (2) tick();
    check("ar_pre_valid", 64'(dtm_valid_o), 64'd1);
    #2 trst_n = 1'b0;
    #1;
    check("ar_valid", 64'(dtm_valid_o), 64'd0);
    check("ar_dtmcs", 64'(dtmcs_o), 64'h00001071);
    check("ar_data_o", 64'(data_o), 64'd0);
    check("ar_dtm_data", 64'(dtm_data_o), 64'd0);
    @(negedge clk);
    trst_n = 1'b1;
    dmi_ready_i = 1'b1;
    repeat (10) tick();
    check("ar_no_stale", 64'(dtm_valid_o), 64'd0);
    dmi_ready_i = 1'b0;
    sb_drain("ar_req");
    check("sb_leftover", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Complete a request handshake without returning a response.
  task automatic serve_accept_only();
    int n;
    n = 0;
    dmi_ready_i = 1'b1;
    while (!dtm_valid_o && n < 30) begin
      tick();
      n++;
    end
    check("accept_valid", 64'(dtm_valid_o), 64'd1);
    tick();
    dmi_ready_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
